// File: rtl/fp_pkg.sv
// Shared single-precision definitions used by the multiplier core and its arbiter wrapper.
package fp_pkg;

  localparam int unsigned FP32_W     = 32;
  localparam int unsigned EXP_BIAS   = 127;
  localparam int unsigned FP32_EXP_W = 8;
  localparam int unsigned FP32_MAN_W = 23;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exponent;
    logic [FP32_MAN_W-1:0] mantissa;
  } fp32_t;

endpackage

// File: rtl/fp_mul.sv
// Combinational single-precision multiplier: truncating, no special-value handling.
module fp_mul
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic [FP32_W-1:0] p
);

  fp32_t       fa;
  fp32_t       fb;
  fp32_t       fp;
  logic [47:0] prod;
  logic [9:0]  exp_sum;

  // Core is purely combinational; the clock port is kept for interface compatibility.
  logic        unused_clk;
  logic [1:0]  unused_exp_hi;
  logic [22:0] unused_prod_lo;

  assign unused_clk     = clk;
  assign unused_exp_hi  = exp_sum[9:8];
  assign unused_prod_lo = prod[22:0];

  assign fa = a;
  assign fb = b;
  assign p  = fp;

  always_comb begin
    prod    = {24'b0, 1'b1, fa.mantissa} * {24'b0, 1'b1, fb.mantissa};
    exp_sum = {2'b0, fa.exponent} + {2'b0, fb.exponent} - 10'(EXP_BIAS) + {9'b0, prod[47]};
    fp.sign     = fa.sign ^ fb.sign;
    fp.exponent = exp_sum[7:0];
    // Normalise by one position when the mantissa product reached [2,4).
    fp.mantissa = prod[47] ? prod[46:24] : prod[45:23];
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin front end sharing one fp_mul core between NUM_REQ requesters,
// wrapped in a two-stage (operand, result) registered pipeline.
module fp_mul_arbiter
  import fp_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*FP32_W-1:0] req_a,
  input  logic [NUM_REQ*FP32_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [FP32_W-1:0]         resp_result,
  input  logic                      resp_ready,
  output logic [31:0]               ops_done
);

  logic              s1_valid;
  logic [FP32_W-1:0] s1_a;
  logic [FP32_W-1:0] s1_b;
  logic [ID_W-1:0]   s1_id;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   rr_ptr_next;

  logic              s2_free;
  logic              s1_adv;
  logic              can_accept;
  logic              accept;
  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   scan_id;
  int unsigned       scan_idx;
  logic [FP32_W-1:0] product;

  // can_accept depends only on pipeline state, never on req_valid.
  assign s2_free    = !resp_valid || resp_ready;
  assign s1_adv     = s1_valid && s2_free;
  assign can_accept = !s1_valid || s2_free;
  assign accept     = grant_found && can_accept && !rst;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = 0;
    scan_id     = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      scan_idx = (32'(rr_ptr) + off) % NUM_REQ;
      scan_id  = ID_W'(scan_idx);
      if (!grant_found && req_valid[scan_id]) begin
        grant_found = 1'b1;
        grant_id    = scan_id;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found && !rst) begin
      req_ready[grant_id] = can_accept;
    end
  end

  assign rr_ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= req_a[FP32_W*grant_id +: FP32_W];
      s1_b     <= req_b[FP32_W*grant_id +: FP32_W];
      s1_id    <= grant_id;
      rr_ptr   <= rr_ptr_next;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  fp_mul u_fp_mul (
    .clk (clk),
    .a   (s1_a),
    .b   (s1_b),
    .p   (product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
    end else if (s1_adv) begin
      resp_valid  <= 1'b1;
      resp_id     <= s1_id;
      resp_result <= product;
    end else if (resp_valid && resp_ready) begin
      resp_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_done <= '0;
    end else if (resp_valid && resp_ready) begin
      ops_done <= ops_done + 32'd1;
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter: directed scenarios plus randomized traffic.
module tb_fp_mul_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic            resp_valid;
  logic [IDW-1:0]  resp_id;
  logic [31:0]     resp_result;
  logic            resp_ready;
  logic [31:0]     ops_done;

  fp_mul_arbiter #(
    .NUM_REQ (N),
    .ID_W    (IDW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_ready  (resp_ready),
    .ops_done    (ops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] res;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          ptr   = 0;
  int          acc_n = 0;
  int          cons_n = 0;
  logic [N-1:0] acc_mask = '0;
  int          cnt[N];
  bit          use_rand = 1'b0;
  logic [31:0] fix_a = '0;
  logic [31:0] fix_b = '0;
  logic        stall_q = 1'b0;
  logic [IDW-1:0] prev_id;
  logic [31:0] prev_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference product straight from the arithmetic rules.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint      ma, mb, p, m;
    int          e;
    logic [7:0]  e8;
    logic [22:0] m23;
    ma = 64'd8388608 + longint'(a[22:0]);
    mb = 64'd8388608 + longint'(b[22:0]);
    p  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p >= (64'd1 << 47)) begin
      e++;
      m = p >> 24;
    end else begin
      m = p >> 23;
    end
    e8  = e[7:0];
    m23 = m[22:0];
    return {a[31] ^ b[31], e8, m23};
  endfunction

  // Requesters: hold operands until accepted, then issue the next op if any remain.
  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && acc_mask[i]) begin
          cnt[i]--;
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i] && cnt[i] > 0) begin
          req_a[32*i +: 32] = use_rand ? $urandom() : fix_a;
          req_b[32*i +: 32] = use_rand ? $urandom() : fix_b;
          req_valid[i] = 1'b1;
        end
      end
    end
  end

  // Grant model: round-robin from ptr; pipeline holds at most two ops.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("ready_in_reset", 64'(req_ready), 64'd0);
        ptr    = 0;
        acc_n  = 0;
        cons_n = 0;
        acc_mask = '0;
        sb.delete();
      end else begin
        int g;
        logic [N-1:0] exp_rdy;
        check("ops_done", 64'(ops_done), 64'(cons_n));
        g = -1;
        for (int off = 0; off < N; off++) begin
          int idx;
          idx = (ptr + off) % N;
          if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_rdy = '0;
        if (g >= 0 && ((acc_n - cons_n) < 2 || resp_ready)) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        acc_mask = exp_rdy;
        if (exp_rdy != '0) begin
          sb.push_back('{g, ref_mul(req_a[32*g +: 32], req_b[32*g +: 32])});
          ptr = (g + 1) % N;
          acc_n++;
        end
        if (resp_valid && resp_ready) cons_n++;
      end
    end
  end

  // Response monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q && resp_valid) begin
          check("stall_id", 64'(resp_id), 64'(prev_id));
          check("stall_result", 64'(resp_result), 64'(prev_res));
        end
        if (resp_valid && resp_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL resp_unexpected: got id %0d result %h, required no response",
                     resp_id, resp_result);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("resp_id", 64'(resp_id), 64'(e.id));
            check("resp_result", 64'(resp_result), 64'(e.res));
          end
        end
        stall_q  = resp_valid && !resp_ready;
        prev_id  = resp_id;
        prev_res = resp_result;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    int ta, tr, run, maxrun, ng;
    int seq[$];
    rst        = 1'b1;
    resp_ready = 1'b1;
    step(2);
    rst = 1'b0;
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    check("reset_ops_done", 64'(ops_done), 64'd0);

    // Single op and its two-cycle latency.
    fix_a = 32'h4000_0000;
    fix_b = 32'h4040_0000;
    cnt[0] = 1;
    ta = -1;
    tr = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ta < 0 && req_valid[0] && req_ready[0]) ta = k;
      if (tr < 0 && resp_valid) begin
        tr = k;
        check("single_result", 64'(resp_result), 64'h40C0_0000);
      end
    end
    check("single_latency", 64'(tr - ta), 64'd2);
    step(1);
    check("single_ops_done", 64'(ops_done), 64'd1);

    // All four at once: grants 0..3, four back-to-back responses.
    do_reset();
    fix_a = 32'h3FC0_0000;
    fix_b = 32'h3FC0_0000;
    for (int i = 0; i < N; i++) cnt[i] = 1;
    run = 0;
    maxrun = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        run++;
        check("simul_result", 64'(resp_result), 64'h4010_0000);
      end else begin
        run = 0;
      end
      if (run > maxrun) maxrun = run;
    end
    check("simul_back_to_back", 64'(maxrun), 64'd4);
    step(1);
    check("simul_ops_done", 64'(ops_done), 64'd4);

    // Fairness between requesters 1 and 3.
    do_reset();
    use_rand = 1'b1;
    cnt[1] = 4;
    cnt[3] = 4;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) seq.push_back(i);
    end
    ng = seq.size();
    check("fair_grants", 64'(ng), 64'd8);
    for (int i = 0; i < ng && i < 8; i++) check("fair_order", 64'(seq[i]), (i % 2) ? 64'd3 : 64'd1);
    step(1);

    // Backpressure from requester 2.
    do_reset();
    use_rand   = 1'b0;
    fix_a      = 32'hC000_0000;
    fix_b      = 32'h3F00_0000;
    resp_ready = 1'b0;
    cnt[2]     = 3;
    step(7);
    check("bp_resp_valid", 64'(resp_valid), 64'd1);
    check("bp_result", 64'(resp_result), 64'hBF80_0000);
    check("bp_third_pending", 64'(req_valid[2]), 64'd1);
    check("bp_ready_low", 64'(req_ready), 64'd0);
    check("bp_ops_done", 64'(ops_done), 64'd0);
    resp_ready = 1'b1;
    step(8);
    check("bp_ops_done_after", 64'(ops_done), 64'd3);

    // Reset with both stages full.
    do_reset();
    use_rand   = 1'b1;
    resp_ready = 1'b0;
    cnt[0] = 1;
    cnt[1] = 1;
    step(5);
    check("rst_pre_full", 64'(resp_valid), 64'd1);
    do_reset();
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_ops_done", 64'(ops_done), 64'd0);
    resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst_no_stale", 64'(resp_valid), 64'd0);
    end
    step(1);
    for (int i = 0; i < N; i++) cnt[i] = 1;
    step(10);
    check("rst_after_ops", 64'(ops_done), 64'd4);

    // Idle.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_ready", 64'(req_ready), 64'd0);
      check("idle_resp_valid", 64'(resp_valid), 64'd0);
    end
    step(1);
    check("idle_ops_done", 64'(ops_done), 64'd4);

    // Randomized traffic and backpressure.
    do_reset();
    use_rand = 1'b1;
    for (int c = 0; c < 400; c++) begin
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if (cnt[i] == 0 && $urandom_range(0, 3) == 0) cnt[i] = $urandom_range(1, 3);
      step(1);
    end
    resp_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (sb.size() == 0 && req_valid == '0 && !resp_valid) break;
      step(1);
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    check("drain_valid", 64'(req_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
